// File: rtl/alu_pkg.sv
// Shared ALU definitions: major op encodings and the packed request bundle
// that the arbiter muxes onto the single ALU instance.
package alu_pkg;

   localparam logic [2:0] OP_ADD        = 3'b000;
   localparam logic [2:0] OP_SLL        = 3'b001;
   localparam logic [2:0] OP_SLT        = 3'b010;
   localparam logic [2:0] OP_SLTU_ALIAS = 3'b011;
   localparam logic [2:0] OP_XOR        = 3'b100;
   localparam logic [2:0] OP_SR         = 3'b101;
   localparam logic [2:0] OP_OR         = 3'b110;
   localparam logic [2:0] OP_AND        = 3'b111;

   // 'unsigned' is a keyword, so the compare qualifier is is_unsigned
   typedef struct packed {
      logic [2:0]  opsel;
      logic        sub;
      logic        is_unsigned;
      logic        arith;
      logic [31:0] op1;
      logic [31:0] op2;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. eq/slt are produced for every opsel; the
// unsigned qualifier selects the compare flavour for both slt flag and SLT op.
module alu
   import alu_pkg::*;
(
   input  logic [2:0]  i_opsel,
   input  logic        i_sub,
   input  logic        i_unsigned,
   input  logic        i_arith,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic [31:0] o_result,
   output logic        o_eq,
   output logic        o_slt
);

   logic [4:0] shamt;

   always_comb begin
      shamt = i_op2[4:0];
      o_eq  = (i_op1 == i_op2);
      o_slt = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
      o_result = '0;
      case (i_opsel)
         OP_ADD:                o_result = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
         OP_SLL:                o_result = i_op1 << shamt;
         OP_SLT, OP_SLTU_ALIAS: o_result = {31'd0, o_slt};
         OP_XOR:                o_result = i_op1 ^ i_op2;
         OP_SR:                 o_result = i_arith ? $unsigned($signed(i_op1) >>> shamt)
                                                   : (i_op1 >> shamt);
         OP_OR:                 o_result = i_op1 | i_op2;
         OP_AND:                o_result = i_op1 & i_op2;
         default:               o_result = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester preferred
// on contention and moves to the other requester on each advance.
module rr_arb2 #(
   parameter int RESET_PRIO = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_valid,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic ptr_q, ptr_d;

   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = ptr_q ? 2'b10 : 2'b01;
         default: o_grant = 2'b00;
      endcase
      // Grant is one-hot on advance: winner 0 hands priority to 1 and vice versa
      ptr_d = ptr_q;
      if (i_advance) ptr_d = o_grant[0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) ptr_q <= 1'(RESET_PRIO);
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a single registered
// response slot. Define ALU_ARBITER_STATS_EN to add accept/conflict counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int TAG_W      = 4,
   parameter int RESET_PRIO = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [2:0]       i_req0_opsel,
   input  logic             i_req0_sub,
   input  logic             i_req0_unsigned,
   input  logic             i_req0_arith,
   input  logic [31:0]      i_req0_op1,
   input  logic [31:0]      i_req0_op2,
   input  logic [TAG_W-1:0] i_req0_tag,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [2:0]       i_req1_opsel,
   input  logic             i_req1_sub,
   input  logic             i_req1_unsigned,
   input  logic             i_req1_arith,
   input  logic [31:0]      i_req1_op1,
   input  logic [31:0]      i_req1_op2,
   input  logic [TAG_W-1:0] i_req1_tag,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [TAG_W-1:0] o_rsp_tag,
   output logic [31:0]      o_rsp_result,
   output logic             o_rsp_eq,
   output logic             o_rsp_slt
`ifdef ALU_ARBITER_STATS_EN
   ,
   output logic [31:0]      o_stat_grant0,
   output logic [31:0]      o_stat_grant1,
   output logic [31:0]      o_stat_conflict
`endif
);

   alu_req_t         req0, req1, sel;
   logic [1:0]       grant;
   logic             can_accept, accept;
   logic [31:0]      alu_result;
   logic             alu_eq, alu_slt;

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic             rsp_eq_q, rsp_eq_d;
   logic             rsp_slt_q, rsp_slt_d;

   rr_arb2 #(.RESET_PRIO(RESET_PRIO)) u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   ({i_req1_valid, i_req0_valid}),
      .i_advance (accept),
      .o_grant   (grant)
   );

   alu u_alu (
      .i_opsel    (sel.opsel),
      .i_sub      (sel.sub),
      .i_unsigned (sel.is_unsigned),
      .i_arith    (sel.arith),
      .i_op1      (sel.op1),
      .i_op2      (sel.op2),
      .o_result   (alu_result),
      .o_eq       (alu_eq),
      .o_slt      (alu_slt)
   );

   always_comb begin
      req0 = '{opsel: i_req0_opsel, sub: i_req0_sub, is_unsigned: i_req0_unsigned,
               arith: i_req0_arith, op1: i_req0_op1, op2: i_req0_op2};
      req1 = '{opsel: i_req1_opsel, sub: i_req1_sub, is_unsigned: i_req1_unsigned,
               arith: i_req1_arith, op1: i_req1_op1, op2: i_req1_op2};
      sel  = grant[1] ? req1 : req0;

      // Slot frees the same cycle it drains, giving bubble-free refill
      can_accept   = ~rsp_valid_q | i_rsp_ready;
      o_req0_ready = grant[0] & can_accept & ~i_rst;
      o_req1_ready = grant[1] & can_accept & ~i_rst;
      accept       = o_req0_ready | o_req1_ready;

      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_result_d = rsp_result_q;
      rsp_eq_d     = rsp_eq_q;
      rsp_slt_d    = rsp_slt_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = o_req1_ready;
         rsp_tag_d    = o_req1_ready ? i_req1_tag : i_req0_tag;
         rsp_result_d = alu_result;
         rsp_eq_d     = alu_eq;
         rsp_slt_d    = alu_slt;
      end else if (i_rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_result_q <= '0;
         rsp_eq_q     <= 1'b0;
         rsp_slt_q    <= 1'b0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_result_q <= rsp_result_d;
         rsp_eq_q     <= rsp_eq_d;
         rsp_slt_q    <= rsp_slt_d;
      end
   end

   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_id     = rsp_id_q;
   assign o_rsp_tag    = rsp_tag_q;
   assign o_rsp_result = rsp_result_q;
   assign o_rsp_eq     = rsp_eq_q;
   assign o_rsp_slt    = rsp_slt_q;

`ifdef ALU_ARBITER_STATS_EN
   logic [31:0] stat_grant0_q, stat_grant0_d;
   logic [31:0] stat_grant1_q, stat_grant1_d;
   logic [31:0] stat_conflict_q, stat_conflict_d;

   always_comb begin
      stat_grant0_d   = stat_grant0_q + 32'(o_req0_ready);
      stat_grant1_d   = stat_grant1_q + 32'(o_req1_ready);
      stat_conflict_d = stat_conflict_q + 32'(i_req0_valid & i_req1_valid & accept);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stat_grant0_q   <= '0;
         stat_grant1_q   <= '0;
         stat_conflict_q <= '0;
      end else begin
         stat_grant0_q   <= stat_grant0_d;
         stat_grant1_q   <= stat_grant1_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign o_stat_grant0   = stat_grant0_q;
   assign o_stat_grant1   = stat_grant1_q;
   assign o_stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares each response as it is consumed.
module tb_alu_arbiter;
   import alu_pkg::*;

   typedef struct packed {
      logic        id;
      logic [3:0]  tag;
      logic [31:0] res;
      logic        eq;
      logic        slt;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_req0_valid, o_req0_ready, i_req0_sub, i_req0_unsigned, i_req0_arith;
   logic [2:0]  i_req0_opsel;
   logic [31:0] i_req0_op1, i_req0_op2;
   logic [3:0]  i_req0_tag;
   logic        i_req1_valid, o_req1_ready, i_req1_sub, i_req1_unsigned, i_req1_arith;
   logic [2:0]  i_req1_opsel;
   logic [31:0] i_req1_op1, i_req1_op2;
   logic [3:0]  i_req1_tag;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_eq, o_rsp_slt;
   logic [3:0]  o_rsp_tag;
   logic [31:0] o_rsp_result;
`ifdef ALU_ARBITER_STATS_EN
   logic [31:0] o_stat_grant0, o_stat_grant1, o_stat_conflict;
`endif

   int   checks = 0;
   int   failures = 0;
   int   n_push = 0;
   int   n_rsp = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_arbiter #(.TAG_W(4), .RESET_PRIO(0)) dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_req0_valid    (i_req0_valid),
      .o_req0_ready    (o_req0_ready),
      .i_req0_opsel    (i_req0_opsel),
      .i_req0_sub      (i_req0_sub),
      .i_req0_unsigned (i_req0_unsigned),
      .i_req0_arith    (i_req0_arith),
      .i_req0_op1      (i_req0_op1),
      .i_req0_op2      (i_req0_op2),
      .i_req0_tag      (i_req0_tag),
      .i_req1_valid    (i_req1_valid),
      .o_req1_ready    (o_req1_ready),
      .i_req1_opsel    (i_req1_opsel),
      .i_req1_sub      (i_req1_sub),
      .i_req1_unsigned (i_req1_unsigned),
      .i_req1_arith    (i_req1_arith),
      .i_req1_op1      (i_req1_op1),
      .i_req1_op2      (i_req1_op2),
      .i_req1_tag      (i_req1_tag),
      .o_rsp_valid     (o_rsp_valid),
      .i_rsp_ready     (i_rsp_ready),
      .o_rsp_id        (o_rsp_id),
      .o_rsp_tag       (o_rsp_tag),
      .o_rsp_result    (o_rsp_result),
      .o_rsp_eq        (o_rsp_eq),
      .o_rsp_slt       (o_rsp_slt)
`ifdef ALU_ARBITER_STATS_EN
      ,
      .o_stat_grant0   (o_stat_grant0),
      .o_stat_grant1   (o_stat_grant1),
      .o_stat_conflict (o_stat_conflict)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic id, input logic [3:0] tag, input logic [31:0] res,
                       input logic eq, input logic slt);
      exp_t e;
      e.id = id; e.tag = tag; e.res = res; e.eq = eq; e.slt = slt;
      sb_q.push_back(e);
      n_push++;
   endtask

   // Monitor: a response is consumed at the next edge whenever valid & ready
   always @(negedge clk) begin
      exp_t e;
      if (!i_rst && o_rsp_valid && i_rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got id=%0d tag=%0d result=0x%0h, expected none",
                     o_rsp_id, o_rsp_tag, o_rsp_result);
         end else begin
            e = sb_q.pop_front();
            n_rsp++;
            chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
            chk("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
            chk("rsp_result", o_rsp_result, e.res);
            chk("rsp_eq", 32'(o_rsp_eq), 32'(e.eq));
            chk("rsp_slt", 32'(o_rsp_slt), 32'(e.slt));
         end
      end
   end

   task automatic drive(input int k, input logic v, input logic [2:0] opsel, input logic sub,
                        input logic uns, input logic arith, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [3:0] tag);
      if (k == 0) begin
         i_req0_valid = v; i_req0_opsel = opsel; i_req0_sub = sub; i_req0_unsigned = uns;
         i_req0_arith = arith; i_req0_op1 = op1; i_req0_op2 = op2; i_req0_tag = tag;
      end else begin
         i_req1_valid = v; i_req1_opsel = opsel; i_req1_sub = sub; i_req1_unsigned = uns;
         i_req1_arith = arith; i_req1_op1 = op1; i_req1_op2 = op2; i_req1_tag = tag;
      end
   endtask

   // Entered and left just after a rising edge; holds the request until accepted
   task automatic issue(input int k, input logic [2:0] opsel, input logic sub, input logic uns,
                        input logic arith, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [3:0] tag, input logic [31:0] er, input logic ee,
                        input logic es);
      bit got;
      got = 0;
      push(k[0], tag, er, ee, es);
      drive(k, 1'b1, opsel, sub, uns, arith, op1, op2, tag);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if ((k == 0) ? o_req0_ready : o_req1_ready) begin
            got = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("issue_ready_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      drive(k, 1'b0, opsel, sub, uns, arith, op1, op2, tag);
   endtask

   task automatic do_reset(input int n);
      i_rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] t0, t1;
      i_rst = 1'b1;
      i_rsp_ready = 1'b1;
      drive(0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 4'd3);
      drive(1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

      // Reset: two edges with a request pending, nothing accepted
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(o_rsp_id), 32'd0);
      chk("reset_rsp_tag", 32'(o_rsp_tag), 32'd0);
      chk("reset_rsp_result", o_rsp_result, 32'd0);
      chk("reset_rsp_eq", 32'(o_rsp_eq), 32'd0);
      chk("reset_rsp_slt", 32'(o_rsp_slt), 32'd0);
      chk("reset_ready0", 32'(o_req0_ready), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      issue(0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b1);
      chk("latency_valid", 32'(o_rsp_valid), 32'd1);
      @(posedge clk); #1;

      // Contention: both valid every cycle, expect strict alternation from requester 0
      do_reset(1);
      t0 = 4'd1;
      t1 = 4'd9;
      for (int c = 0; c < 10; c++) begin
         drive(0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, {28'd0, t0}, 32'd100, t0);
         drive(1, 1'b1, OP_OR, 1'b0, 1'b0, 1'b0, {28'd0, t1}, 32'h100, t1);
         @(negedge clk);
         chk("contend_ready0", 32'(o_req0_ready), 32'((c % 2) == 0));
         chk("contend_ready1", 32'(o_req1_ready), 32'((c % 2) == 1));
         if ((c % 2) == 0) push(1'b0, t0, 32'd100 + {28'd0, t0}, 1'b0, 1'b1);
         else              push(1'b1, t1, 32'h100 | {28'd0, t1}, 1'b0, 1'b1);
         @(posedge clk); #1;
         if ((c % 2) == 0) t0 = t0 + 4'd1;
         else              t1 = t1 + 4'd1;
      end
`ifdef ALU_ARBITER_STATS_EN
      chk("stat_grant0", o_stat_grant0, 32'd5);
      chk("stat_grant1", o_stat_grant1, 32'd5);
      chk("stat_conflict", o_stat_conflict, 32'd10);
`endif
      drive(0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      do_reset(1);
`ifdef ALU_ARBITER_STATS_EN
      chk("stat_clr_grant0", o_stat_grant0, 32'd0);
      chk("stat_clr_grant1", o_stat_grant1, 32'd0);
      chk("stat_clr_conflict", o_stat_conflict, 32'd0);
`endif

      // Backpressure: response held for 4 cycles, req1 blocked, then zero-bubble refill
      i_rsp_ready = 1'b0;
      push(1'b0, 4'd5, 32'd0, 1'b1, 1'b0);
      drive(0, 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 4'd5);
      @(negedge clk);
      chk("bp_ready0", 32'(o_req0_ready), 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      push(1'b1, 4'd6, 32'hFFFF_FFFF, 1'b0, 1'b1);
      drive(1, 1'b1, OP_SR, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd31, 4'd6);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
         chk("bp_hold_result", o_rsp_result, 32'd0);
         chk("bp_hold_eq", 32'(o_rsp_eq), 32'd1);
         chk("bp_ready1", 32'(o_req1_ready), 32'd0);
         @(posedge clk); #1;
      end
      i_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready1", 32'(o_req1_ready), 32'd1);
      @(posedge clk); #1;
      drive(1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      chk("bp_nobubble_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_nobubble_id", 32'(o_rsp_id), 32'd1);

      // Operations through requester 1, back to back
      issue(1, OP_SLT,        1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd1, 1'b0, 1'b1);
      issue(1, OP_SLT,        1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0, 1'b0, 1'b0);
      issue(1, OP_SLTU_ALIAS, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0, 1'b1);
      issue(1, OP_SLTU_ALIAS, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 1'b0, 1'b0);
      issue(1, OP_XOR, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd5, 32'hF00F_F00F, 1'b0, 1'b1);
      issue(1, OP_AND, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd6, 32'h0F00_0F00, 1'b0, 1'b1);
      issue(1, OP_SR,  1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 4'd7, 32'h0800_0000, 1'b0, 1'b1);
      issue(1, OP_ADD, 1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 4'd8, 32'd7, 1'b0, 1'b0);
      issue(1, OP_SLL, 1'b0, 1'b0, 1'b0, 32'd1, 32'h24, 4'd9, 32'd16, 1'b0, 1'b1);
      issue(1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd10, 32'd1, 1'b0, 1'b1);
      issue(1, OP_OR,  1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 4'd11, 32'h0000_0FF0, 1'b0, 1'b1);
      @(posedge clk); #1;

      // Reset mid-operation: a stalled response must vanish and the pointer return home
      i_rsp_ready = 1'b0;
      drive(0, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 4'd15);
      @(negedge clk);
      chk("rstmid_ready0", 32'(o_req0_ready), 32'd1);
      @(posedge clk); #1;
      chk("rstmid_stale_present", 32'(o_rsp_valid), 32'd1);
      i_rst = 1'b1;
      i_rsp_ready = 1'b1;
      drive(0, 1'b1, OP_AND, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd7);
      drive(1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 4'd8);
      @(negedge clk);
      chk("rstmid_ready0_in_rst", 32'(o_req0_ready), 32'd0);
      chk("rstmid_ready1_in_rst", 32'(o_req1_ready), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      chk("rstmid_valid_cleared", 32'(o_rsp_valid), 32'd0);
      chk("rstmid_result_cleared", o_rsp_result, 32'd0);
      push(1'b0, 4'd7, 32'h00F0_00F0, 1'b0, 1'b1);
      @(negedge clk);
      chk("rstmid_ptr_ready0", 32'(o_req0_ready), 32'd1);
      chk("rstmid_ptr_ready1", 32'(o_req1_ready), 32'd0);
      @(posedge clk); #1;
      drive(0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      push(1'b1, 4'd8, 32'h8000_0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("rstmid_ready1_next", 32'(o_req1_ready), 32'd1);
      @(posedge clk); #1;
      drive(1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(posedge clk);
      #1;

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("rsp_count", 32'(n_rsp), 32'(n_push));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters, e.g. the execute stage and a branch/address unit, using valid/ready handshakes. Arbitration is round-robin. Each accepted operation produces one registered response one cycle later. The response carries the requester ID and a pass-through tag. The block owns the alu instance and drives all of its control inputs.

Parameters:
TAG_W, 4, width of the opaque per-request tag returned with the response (legal 1..16)
RESET_PRIO, 0, requester preferred first after reset (0 or 1)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_req0_valid  input  1  requester 0 has an operation
o_req0_ready  output  1  requester 0 operation accepted this cycle
i_req0_opsel  input  3  alu major op select (000 add/sub … 111 and)
i_req0_sub  input  1  subtract qualifier
i_req0_unsigned  input  1  unsigned compare qualifier
i_req0_arith  input  1  arithmetic right-shift qualifier
i_req0_op1  input  32  operand 1
i_req0_op2  input  32  operand 2
i_req0_tag  input  TAG_W  opaque tag
i_req1_*  (same set as i_req0_*)  requester 1
o_rsp_valid  output  1  response register holds a result
i_rsp_ready  input  1  consumer accepts response
o_rsp_id  output  1  requester that issued the operation
o_rsp_tag  output  TAG_W  tag of that operation
o_rsp_result  output  32  alu result
o_rsp_eq  output  1  alu equality flag
o_rsp_slt  output  1  alu set-less-than flag

Behaviour:
- Reset: one clock, synchronous, active-high.
  - o_rsp_valid=0; o_rsp_id/o_rsp_tag/o_rsp_result/o_rsp_eq/o_rsp_slt=0.
  - Priority pointer = RESET_PRIO.
  - Reset mid-operation discards a pending response; requests presented during reset are not accepted (readies forced 0 while i_rst=1).
- Space: can_accept = ~o_rsp_valid | i_rsp_ready. A single response register is used, with zero-bubble drain-and-refill.
- Grant (combinational):
  - Only one valid: that requester wins.
  - Both valid: requester equal to the pointer wins.
  - Neither valid: no grant.
- Ready: o_reqK_ready = grantK & can_accept & ~i_rst. Ready may depend on both valids. A requester's valid must not depend on its ready. Once asserted, valid and payload must hold until accepted.
- Datapath: the alu inputs are muxed from the granted requester; when nothing is granted, requester 0's inputs are selected.
- Accept (valid&ready on K):
  - Next edge, the response register loads result/eq/slt, id=K, tag.
  - o_rsp_valid=1.
  - Pointer <= ~K.
- Latency: exactly 1 cycle from accept to o_rsp_valid.
- Throughput: 1 op/cycle while i_rsp_ready=1.
- No accept and i_rsp_ready & o_rsp_valid: o_rsp_valid <= 0. Payload holds its last value.
- Stall: while o_rsp_valid & ~i_rsp_ready, response outputs hold stable, no ready is asserted, and the pointer does not move.
- Fairness: with both requesters continuously valid and no stall, grants alternate 0,1,0,1…. Worst-case wait is 1 accepted op of the other requester.
- Result semantics are exactly the alu's:
  - Shift amount is op2[4:0].
  - opsel 010 and 011 both give set-less-than.
  - Carry is discarded.
  - eq and slt are valid for every opsel.

Optional Feature:
Macro ALU_ARBITER_STATS_EN adds three output ports:
- o_stat_grant0 32: count of accepts for requester 0.
- o_stat_grant1 32: count of accepts for requester 1.
- o_stat_conflict 32: cycles with both valid and one accepted.

Counter rules:
- Cleared by i_rst.
- Wrap at 2^32.
- Increment on the same edge as the accept.

Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds the opsel localparams (OP_ADD=000, OP_SLL=001, OP_SLT=010, OP_SLTU_ALIAS=011, OP_XOR=100, OP_SR=101, OP_OR=110, OP_AND=111).
- alu_pkg also holds a packed alu_req_t {opsel, sub, unsigned, arith, op1, op2}.
- One natural sub-module is rr_arb2: 2-way round-robin grant with pointer register, inputs valid[1:0] and advance, output grant[1:0].
- The existing alu is instantiated unchanged.

Test Plan:
- Reset: after i_rst for 2 cycles → all outputs 0. Then req0 add op1=5 op2=7 → ready0=1, next cycle rsp valid, id=0, result=12, eq=0, slt=1.
- Contention: both valid every cycle, rsp_ready=1, req0 tags 1,2,3 and req1 tags 9,10,11 → response order (id,tag) = (0,1),(1,9),(0,2),(1,10),(0,3),(1,11).
- Backpressure: req0 sub op1=3 op2=3 accepted, rsp_ready=0 for 4 cycles with req1 valid → rsp holds result=0, eq=1 stable, ready1=0. Release → req1 accepted the same cycle rsp drains, with no bubble.
- Ops via req1:
  - sra op1=0x80000000 op2=31 arith=1 → 0xFFFFFFFF.
  - slt signed -1 vs 1 → result 1, slt=1.
  - sltu 0xFFFFFFFF vs 1 → result 0.
  - opsel 011 matches 010.
- Reset mid-operation: i_rst asserted while o_rsp_valid=1 and ~i_rsp_ready → next cycle o_rsp_valid=0, pointer=RESET_PRIO, no stale response afterwards.
- With ALU_ARBITER_STATS_EN: 10 contention cycles with no stall → grant0=5, grant1=5, conflict=10. Reset clears all three counters.
